logic_bist_controller: RTL and testbench
========================================

// Module: logic_bist_controller
// PURPOSE
// On-chip logic BIST engine for the scan-inserted system: drives CHAIN_COUNT scan chains from a
// Galois LFSR and compacts chain outputs into a MISR, so the device self-tests without an ATE.
// Sits beside the scan_clk/test_mode muxing. In BIST mode its SE/SI/SO replace the top-level scan
// ports, and it reports a pass/fail signature against a programmed golden value.
// PARAMETERS
// CHAIN_COUNT     3        number of scan chains driven/observed (1..LFSR_WIDTH, 1..MISR_WIDTH)
// CHAIN_LENGTH    64       flops in the longest chain = shift cycles per load/unload
// PATTERN_COUNT   256      number of capture patterns applied
// LFSR_WIDTH      16       pattern-generator width
// LFSR_SEED       16'hACE1 LFSR value loaded on start (must be non-zero)
// LFSR_POLY       16'hB400 Galois feedback mask for LFSR
// MISR_WIDTH      16       signature register width
// MISR_POLY       16'hB400 Galois feedback mask for MISR
// PORTS
// clk                 in   1             BIST clock (scan clock domain)
// reset               in   1             synchronous, active-high reset
// bist_start          in   1             1-cycle request; accepted in IDLE or DONE only
// bist_abort          in   1             return to IDLE from any state; has priority over bist_start
// expected_signature  in   MISR_WIDTH    golden signature, sampled when DONE is entered
// SE                  out  1             scan enable to all chains (1 = shift, 0 = capture)
// SI                  out  CHAIN_COUNT   serial data into chains
// SO                  in   CHAIN_COUNT   serial data out of chains
// bist_busy           out  1             high in SHIFT/CAPTURE/UNLOAD
// bist_done           out  1             high while in DONE
// bist_pass           out  1             signature == expected_signature; valid only when bist_done=1
// signature           out  MISR_WIDTH    current MISR contents
// BEHAVIOUR
// - Reset: state=IDLE. SE, SI, bist_busy, bist_done, bist_pass = 0. signature = 0. LFSR = LFSR_SEED.
//   Counters = 0.
// - All outputs are registered or derived from registered state. No combinational path from SO
//   to any output.
// - LFSR step: lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_POLY : lfsr>>1. SI[i] = lfsr[i] in shifting states.
// - MISR step: misr <= (misr[0] ? (misr>>1)^MISR_POLY : misr>>1) ^ {0.., SO}, with SO at bit 0 upward.
// - IDLE: SE=0, SI=0.
//   - bist_start -> SHIFT next cycle. Loads LFSR=LFSR_SEED, MISR=0, shift_cnt=0, pat_cnt=0,
//     first_load=1.
// - SHIFT: SE=1 for exactly CHAIN_LENGTH cycles. LFSR steps each cycle.
//   - MISR steps each cycle except while first_load=1; the initial chain contents are unknown
//     and are not compacted.
//   - At shift_cnt==CHAIN_LENGTH-1 -> CAPTURE; shift_cnt clears.
// - CAPTURE: single cycle. SE=0, SI=0, LFSR and MISR hold. pat_cnt++ and first_load clears.
//   - If the new pat_cnt==PATTERN_COUNT -> UNLOAD, else -> SHIFT.
//   - Each SHIFT after the first overlaps the unload of the previous capture with the load of
//     the next pattern.
// - UNLOAD: SE=1, SI=0, LFSR holds. MISR steps for CHAIN_LENGTH cycles, then -> DONE.
// - DONE: bist_done=1. bist_pass = (signature==expected_signature), registered on DONE entry.
//   - Holds until bist_start (restart exactly as from IDLE) or bist_abort (-> IDLE).
// - Total busy cycles: PATTERN_COUNT*(CHAIN_LENGTH+1)+CHAIN_LENGTH.
//   bist_busy rises the cycle after the accepted bist_start.
// - bist_start while busy: ignored.
// - bist_abort in any state: next cycle IDLE, SE=0, busy=0, done=0, pass=0. signature is retained.
// - reset mid-run: same outcome as abort, plus signature=0 and LFSR=LFSR_SEED.
// - Counter widths: $clog2(CHAIN_LENGTH+1) and $clog2(PATTERN_COUNT+1). No wrap-around occurs.
// TESTING (CHAIN_COUNT=3, CHAIN_LENGTH=4, PATTERN_COUNT=2, 16-bit seed/polys as default)
// 1. Assert reset 2 cycles -> SE=0, SI=0, busy=0, done=0, pass=0, signature=16'h0000.
// 2. SO tied 0, expected=0, pulse start -> busy high 14 cycles.
//    SE sequence: 1x4, 0, 1x4, 0, 1x4. Then done=1, signature=0, pass=1.
// 3. SO driven from a 3x4 shift-register chain model (capture = invert contents) with golden
//    from a C model -> pass=1. Rerun with expected^16'h0001 -> pass=0.
// 4. Check SI over the first 4 cycles after start: SI = lfsr[2:0] of seed 16'hACE1 and its next
//    3 LFSR states, i.e. SI=3'b001 in cycle 1.
// 5. Abort on busy cycle 6 -> next cycle IDLE, SE=0, busy=0.
//    A following start reproduces the test-4 SI sequence exactly.
// 6. start pulsed during SHIFT -> ignored, run still takes 14 cycles.
//    start in DONE -> restart, done=0 the next cycle. Synchronous reset mid-UNLOAD -> signature=0.

Source files
------------

// File: rtl/logic_bist_controller.sv
// Logic BIST engine: a Galois LFSR feeds the scan chains and a Galois MISR
// compacts what comes back. Runs PATTERN_COUNT load/capture rounds, then
// a final unload, and reports a pass/fail signature against a golden value.
module logic_bist_controller #(
    parameter int unsigned           CHAIN_COUNT   = 3,
    parameter int unsigned           CHAIN_LENGTH  = 64,
    parameter int unsigned           PATTERN_COUNT = 256,
    parameter int unsigned           LFSR_WIDTH    = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = 16'hACE1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 16'hB400,
    parameter int unsigned           MISR_WIDTH    = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY     = 16'hB400
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bist_start,
    input  logic                   bist_abort,
    input  logic [MISR_WIDTH-1:0]  expected_signature,
    output logic                   SE,
    output logic [CHAIN_COUNT-1:0] SI,
    input  logic [CHAIN_COUNT-1:0] SO,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   bist_pass,
    output logic [MISR_WIDTH-1:0]  signature
);

    localparam int unsigned SCW = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned PCW = $clog2(PATTERN_COUNT + 1);
    localparam logic [SCW-1:0] SHIFT_LAST = SCW'(CHAIN_LENGTH - 1);
    localparam logic [PCW-1:0] PAT_LAST   = PCW'(PATTERN_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t                  state, state_next;
    logic [LFSR_WIDTH-1:0]   lfsr, lfsr_next;
    logic [MISR_WIDTH-1:0]   misr, misr_next, so_ext;
    logic [SCW-1:0]          shift_cnt;
    logic [PCW-1:0]          pat_cnt, pat_cnt_inc;
    logic                    first_load;
    logic                    pass_q;

    logic start_run, lfsr_step, misr_step, shift_inc, shift_clr, pat_inc, pass_load;

    // Galois step of both registers; SO enters the MISR at bit 0 upward
    always_comb begin
        so_ext = '0;
        so_ext[CHAIN_COUNT-1:0] = SO;
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
        misr_next = (misr[0] ? ((misr >> 1) ^ MISR_POLY) : (misr >> 1)) ^ so_ext;
        pat_cnt_inc = pat_cnt + PCW'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath controls; abort overrides everything
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        lfsr_step  = 1'b0;
        misr_step  = 1'b0;
        shift_inc  = 1'b0;
        shift_clr  = 1'b0;
        pat_inc    = 1'b0;
        pass_load  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    state_next = S_SHIFT;
                    start_run  = 1'b1;
                end
            end
            S_SHIFT: begin
                lfsr_step = 1'b1;
                misr_step = !first_load;
                if (shift_cnt == SHIFT_LAST) begin
                    state_next = S_CAPTURE;
                    shift_clr  = 1'b1;
                end else begin
                    shift_inc = 1'b1;
                end
            end
            S_CAPTURE: begin
                pat_inc    = 1'b1;
                state_next = (pat_cnt_inc == PAT_LAST) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                misr_step = 1'b1;
                if (shift_cnt == SHIFT_LAST) begin
                    state_next = S_DONE;
                    shift_clr  = 1'b1;
                    pass_load  = 1'b1;
                end else begin
                    shift_inc = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (bist_abort) begin
            state_next = S_IDLE;
            start_run  = 1'b0;
            lfsr_step  = 1'b0;
            misr_step  = 1'b0;
            shift_inc  = 1'b0;
            shift_clr  = 1'b0;
            pat_inc    = 1'b0;
            pass_load  = 1'b0;
        end
    end

    // LFSR, MISR, counters and pass flag; pass compares the final MISR value
    // as it is written, so it is valid in the first DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= LFSR_SEED;
            misr       <= '0;
            shift_cnt  <= '0;
            pat_cnt    <= '0;
            first_load <= 1'b0;
            pass_q     <= 1'b0;
        end else if (bist_abort) begin
            pass_q <= 1'b0;
        end else if (start_run) begin
            lfsr       <= LFSR_SEED;
            misr       <= '0;
            shift_cnt  <= '0;
            pat_cnt    <= '0;
            first_load <= 1'b1;
            pass_q     <= 1'b0;
        end else begin
            if (lfsr_step) lfsr <= lfsr_next;
            if (misr_step) misr <= misr_next;
            if (shift_clr)      shift_cnt <= '0;
            else if (shift_inc) shift_cnt <= shift_cnt + SCW'(1);
            if (pat_inc) begin
                pat_cnt    <= pat_cnt_inc;
                first_load <= 1'b0;
            end
            if (pass_load) pass_q <= (misr_next == expected_signature);
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        SE        = (state == S_SHIFT) || (state == S_UNLOAD);
        SI        = (state == S_SHIFT) ? lfsr[CHAIN_COUNT-1:0] : '0;
        bist_busy = (state == S_SHIFT) || (state == S_CAPTURE) || (state == S_UNLOAD);
        bist_done = (state == S_DONE);
        bist_pass = pass_q;
        signature = misr;
    end

endmodule

// File: tb/tb_logic_bist_controller.sv
// Directed bench for logic_bist_controller with a scan-chain model on SO
// and a scoreboard of per-cycle SE/SI expectations.
module tb_logic_bist_controller;

    localparam int CC   = 3;
    localparam int CL   = 4;
    localparam int PC   = 2;
    localparam int BUSY = PC * (CL + 1) + CL;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] LPOLY = 16'hB400;
    localparam logic [15:0] MPOLY = 16'hB400;

    logic          clk = 1'b0;
    logic          reset, bist_start, bist_abort;
    logic [15:0]   expected_signature;
    logic          SE;
    logic [CC-1:0] SI, SO;
    logic          bist_busy, bist_done, bist_pass;
    logic [15:0]   signature;

    logic          so_tie;
    logic [CL-1:0] chain [CC];
    logic [15:0]   golden;

    typedef struct packed {
        logic          se;
        logic [CC-1:0] si;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    logic_bist_controller #(
        .CHAIN_COUNT  (CC),
        .CHAIN_LENGTH (CL),
        .PATTERN_COUNT(PC),
        .LFSR_WIDTH   (16),
        .LFSR_SEED    (SEED),
        .LFSR_POLY    (LPOLY),
        .MISR_WIDTH   (16),
        .MISR_POLY    (MPOLY)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bist_start        (bist_start),
        .bist_abort        (bist_abort),
        .expected_signature(expected_signature),
        .SE                (SE),
        .SI                (SI),
        .SO                (SO),
        .bist_busy         (bist_busy),
        .bist_done         (bist_done),
        .bist_pass         (bist_pass),
        .signature         (signature)
    );

    always #5 clk = ~clk;

    // Scan chains: shift when SE=1, invert contents on the capture cycle
    always @(posedge clk) begin
        for (int i = 0; i < CC; i++) begin
            if (SE)             chain[i] <= {chain[i][CL-2:0], SI[i]};
            else if (bist_busy) chain[i] <= ~chain[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CC; i++) SO[i] = so_tie ? 1'b0 : chain[i][CL-1];
    end

    function automatic logic [15:0] gstep(input logic [15:0] v, input logic [15:0] poly);
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    // Whole-run reference: LFSR patterns through chains, compaction skipped on first load
    function automatic logic [15:0] golden_sig();
        logic [15:0]   lf = SEED;
        logic [15:0]   mi = '0;
        logic [CL-1:0] ch [CC];
        logic [15:0]   so;
        for (int i = 0; i < CC; i++) ch[i] = '0;
        for (int p = 0; p < PC; p++) begin
            for (int c = 0; c < CL; c++) begin
                so = '0;
                for (int i = 0; i < CC; i++) so[i] = ch[i][CL-1];
                if (p != 0) mi = gstep(mi, MPOLY) ^ so;
                for (int i = 0; i < CC; i++) ch[i] = {ch[i][CL-2:0], lf[i]};
                lf = gstep(lf, LPOLY);
            end
            for (int i = 0; i < CC; i++) ch[i] = ~ch[i];
        end
        for (int c = 0; c < CL; c++) begin
            so = '0;
            for (int i = 0; i < CC; i++) so[i] = ch[i][CL-1];
            mi = gstep(mi, MPOLY) ^ so;
            for (int i = 0; i < CC; i++) ch[i] = {ch[i][CL-2:0], 1'b0};
        end
        return mi;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected SE/SI for every busy cycle of one run
    task automatic push_expected();
        logic [15:0] lf = SEED;
        exp_t e;
        for (int p = 0; p < PC; p++) begin
            for (int c = 0; c < CL; c++) begin
                e.se = 1'b1;
                e.si = lf[CC-1:0];
                sb.push_back(e);
                lf = gstep(lf, LPOLY);
            end
            e.se = 1'b0;
            e.si = '0;
            sb.push_back(e);
        end
        for (int c = 0; c < CL; c++) begin
            e.se = 1'b1;
            e.si = '0;
            sb.push_back(e);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_sig);
        check({tag, "_se"},   32'(SE),        32'd0);
        check({tag, "_si"},   32'(SI),        32'd0);
        check({tag, "_busy"}, 32'(bist_busy), 32'd0);
        check({tag, "_done"}, 32'(bist_done), 32'd0);
        check({tag, "_pass"}, 32'(bist_pass), 32'd0);
        check({tag, "_sig"},  32'(signature), 32'(exp_sig));
    endtask

    // One run; optional stray start, abort or reset on a given busy cycle
    task automatic run(input string name, input logic [15:0] exp_sig, input logic exp_pass,
                       input int start_at, input int abort_at, input int reset_at);
        exp_t e;
        push_expected();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int cyc = 1; cyc <= BUSY; cyc++) begin
            e = sb.pop_front();
            check($sformatf("%s_busy_c%0d", name, cyc), 32'(bist_busy), 32'd1);
            check($sformatf("%s_done_c%0d", name, cyc), 32'(bist_done), 32'd0);
            check($sformatf("%s_se_c%0d", name, cyc),   32'(SE),        32'(e.se));
            check($sformatf("%s_si_c%0d", name, cyc),   32'(SI),        32'(e.si));
            if (cyc == start_at) bist_start = 1'b1;
            if (cyc == abort_at) bist_abort = 1'b1;
            if (cyc == reset_at) reset = 1'b1;
            tick();
            bist_start = 1'b0;
            if (cyc == abort_at || cyc == reset_at) begin
                bist_abort = 1'b0;
                reset      = 1'b0;
                check_idle({name, "_stop"}, exp_sig);
                sb.delete();
                return;
            end
        end
        check({name, "_end_busy"}, 32'(bist_busy), 32'd0);
        check({name, "_end_done"}, 32'(bist_done), 32'd1);
        check({name, "_end_se"},   32'(SE),        32'd0);
        check({name, "_end_sig"},  32'(signature), 32'(exp_sig));
        check({name, "_end_pass"}, 32'(bist_pass), 32'(exp_pass));
        tick();
        check({name, "_hold_done"}, 32'(bist_done), 32'd1);
    endtask

    initial begin
        reset              = 1'b1;
        bist_start         = 1'b0;
        bist_abort         = 1'b0;
        expected_signature = '0;
        so_tie             = 1'b1;
        tick();
        tick();
        check_idle("reset", 16'h0000);
        reset = 1'b0;
        tick();

        // SO tied low: signature stays zero and matches a zero golden
        run("zero", 16'h0000, 1'b1, 0, 0, 0);

        // Chain model on SO against the reference signature
        so_tie             = 1'b0;
        golden             = golden_sig();
        expected_signature = golden;
        run("chain", golden, 1'b1, 0, 0, 0);
        expected_signature = golden ^ 16'h0001;
        run("badgold", golden, 1'b0, 0, 0, 0);
        expected_signature = golden;

        // Start while shifting is ignored
        run("stray", golden, 1'b1, 3, 0, 0);

        // Abort on busy cycle 6, then a clean rerun from IDLE
        run("abort", 16'h0000, 1'b0, 0, 6, 0);
        run("rerun", golden, 1'b1, 0, 0, 0);

        // Reset during UNLOAD clears the signature; LFSR restarts from seed
        run("rst", 16'h0000, 1'b0, 0, 0, 12);
        run("postrst", golden, 1'b1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
